// File: rtl/pci_cfg_target.sv
// PCI configuration-space target: claims Type-0 config cycles, hands them to a
// config-space sequencer, and drives DEVSEL#/TRDY#/STOP# with Retry and disconnect support.
module pci_cfg_target #(
    parameter int LAT_MAX = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_n,
    input  logic       irdy_n,
    input  logic       idsel,
    input  logic [3:0] cbe_n,
    input  logic [7:0] ad,
    input  logic       cfg_drdy,
    output logic       acc_cfg,
    output logic       cfg_sent,
    output logic       cfg_xfer,
    output logic       cfg_wr,
    output logic [5:0] cfg_addr,
    output logic [3:0] cfg_be,
    output logic       devsel_n,
    output logic       trdy_n,
    output logic       stop_n,
    output logic       tgt_oe,
    output logic       ad_oe
);

    localparam int CW = $clog2(LAT_MAX) + 1;
    localparam logic [CW-1:0] LAT_LAST = CW'(LAT_MAX - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLAIM = 3'd1,
        S_WAIT  = 3'd2,
        S_DATA  = 3'd3,
        S_STOPW = 3'd4,
        S_TURN  = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          frame_prev_q;
    logic          drdy_seen_q, drdy_seen_d;
    logic          xfer_seen_q, xfer_seen_d;
    logic          cfg_wr_q, cfg_wr_d;
    logic [5:0]    cfg_addr_q, cfg_addr_d;
    logic [3:0]    cfg_be_q, cfg_be_d;
    logic          acc_cfg_q, acc_cfg_d;
    logic          cfg_sent_q, cfg_sent_d;
    logic          cfg_xfer_q, cfg_xfer_d;
    logic          devsel_n_q, devsel_n_d;
    logic          trdy_n_q, trdy_n_d;
    logic          stop_n_q, stop_n_d;
    logic          tgt_oe_q, tgt_oe_d;
    logic          ad_oe_q, ad_oe_d;

    logic          addr_phase_s;
    logic          claim_ok_s;
    logic          xfer_s;

    // A claim needs a fresh FRAME# falling edge; frame_prev_q resets low so a
    // FRAME# already asserted at reset release is not mistaken for one.
    assign addr_phase_s = ~frame_n & frame_prev_q;
    assign claim_ok_s   = idsel & (cbe_n[3:1] == 3'b101) & (ad[1:0] == 2'b00);
    assign xfer_s       = (state_q == S_DATA) & ~irdy_n;

    // Next-state logic of the target sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (addr_phase_s && claim_ok_s) state_d = S_CLAIM;
                else                            state_d = S_IDLE;
            end
            S_CLAIM: state_d = S_WAIT;
            S_WAIT: begin
                if (cfg_drdy)               state_d = S_DATA;
                else if (cnt_q == LAT_LAST) state_d = S_STOPW;
                else                        state_d = S_WAIT;
            end
            S_DATA: begin
                if (!irdy_n) state_d = frame_n ? S_TURN : S_STOPW;
                else         state_d = S_DATA;
            end
            S_STOPW: begin
                if (frame_n && drdy_seen_q) state_d = S_TURN;
                else                        state_d = S_STOPW;
            end
            S_TURN:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Latency counter, sticky flags and latched command/address/byte enables.
    always_comb begin
        cnt_d       = cnt_q;
        drdy_seen_d = drdy_seen_q;
        xfer_seen_d = xfer_seen_q;
        cfg_addr_d  = cfg_addr_q;
        cfg_wr_d    = cfg_wr_q;
        cfg_be_d    = cfg_be_q;
        case (state_q)
            S_IDLE: begin
                cnt_d       = {CW{1'b0}};
                drdy_seen_d = 1'b0;
                xfer_seen_d = 1'b0;
                if (addr_phase_s && claim_ok_s) begin
                    cfg_addr_d = ad[7:2];
                    cfg_wr_d   = cbe_n[0];
                end else begin
                    cfg_addr_d = cfg_addr_q;
                    cfg_wr_d   = cfg_wr_q;
                end
            end
            S_CLAIM, S_WAIT: begin
                cnt_d       = cnt_q + CNT_ONE;
                drdy_seen_d = drdy_seen_q | cfg_drdy;
            end
            S_STOPW: drdy_seen_d = drdy_seen_q | cfg_drdy;
            S_DATA: begin
                if (xfer_s) begin
                    xfer_seen_d = 1'b1;
                    cfg_be_d    = ~cbe_n;
                end else begin
                    xfer_seen_d = xfer_seen_q;
                    cfg_be_d    = cfg_be_q;
                end
            end
            default: cnt_d = cnt_q;
        endcase
    end

    // Output decode from the upcoming state so every output leaves a flop.
    always_comb begin
        acc_cfg_d  = 1'b0;
        cfg_sent_d = 1'b0;
        cfg_xfer_d = 1'b0;
        devsel_n_d = 1'b1;
        trdy_n_d   = 1'b1;
        stop_n_d   = 1'b1;
        tgt_oe_d   = 1'b0;
        ad_oe_d    = 1'b0;
        case (state_d)
            S_IDLE: tgt_oe_d = 1'b0;
            S_CLAIM: begin
                acc_cfg_d  = 1'b1;
                devsel_n_d = 1'b0;
                tgt_oe_d   = 1'b1;
            end
            S_WAIT: begin
                devsel_n_d = 1'b0;
                tgt_oe_d   = 1'b1;
            end
            S_DATA: begin
                devsel_n_d = 1'b0;
                trdy_n_d   = 1'b0;
                stop_n_d   = frame_n;
                tgt_oe_d   = 1'b1;
                ad_oe_d    = ~cfg_wr_d;
            end
            S_STOPW: begin
                devsel_n_d = 1'b0;
                stop_n_d   = 1'b0;
                tgt_oe_d   = 1'b1;
            end
            S_TURN: begin
                cfg_sent_d = 1'b1;
                cfg_xfer_d = xfer_seen_d;
                tgt_oe_d   = 1'b1;
            end
            default: tgt_oe_d = 1'b0;
        endcase
    end

    // State, datapath and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= {CW{1'b0}};
            frame_prev_q <= 1'b0;
            drdy_seen_q  <= 1'b0;
            xfer_seen_q  <= 1'b0;
            cfg_wr_q     <= 1'b0;
            cfg_addr_q   <= 6'd0;
            cfg_be_q     <= 4'd0;
            acc_cfg_q    <= 1'b0;
            cfg_sent_q   <= 1'b0;
            cfg_xfer_q   <= 1'b0;
            devsel_n_q   <= 1'b1;
            trdy_n_q     <= 1'b1;
            stop_n_q     <= 1'b1;
            tgt_oe_q     <= 1'b0;
            ad_oe_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            frame_prev_q <= frame_n;
            drdy_seen_q  <= drdy_seen_d;
            xfer_seen_q  <= xfer_seen_d;
            cfg_wr_q     <= cfg_wr_d;
            cfg_addr_q   <= cfg_addr_d;
            cfg_be_q     <= cfg_be_d;
            acc_cfg_q    <= acc_cfg_d;
            cfg_sent_q   <= cfg_sent_d;
            cfg_xfer_q   <= cfg_xfer_d;
            devsel_n_q   <= devsel_n_d;
            trdy_n_q     <= trdy_n_d;
            stop_n_q     <= stop_n_d;
            tgt_oe_q     <= tgt_oe_d;
            ad_oe_q      <= ad_oe_d;
        end
    end

    assign acc_cfg  = acc_cfg_q;
    assign cfg_sent = cfg_sent_q;
    assign cfg_xfer = cfg_xfer_q;
    assign cfg_wr   = cfg_wr_q;
    assign cfg_addr = cfg_addr_q;
    assign cfg_be   = cfg_be_q;
    assign devsel_n = devsel_n_q;
    assign trdy_n   = trdy_n_q;
    assign stop_n   = stop_n_q;
    assign tgt_oe   = tgt_oe_q;
    assign ad_oe    = ad_oe_q;

endmodule

// File: tb/tb_pci_cfg_target.sv
// Bench for pci_cfg_target: directed scenarios plus randomized config cycles,
// all outputs compared every cycle against a transaction-level reference model.
module tb_pci_cfg_target;

    localparam int LAT_MAX = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       frame_n, irdy_n, idsel, cfg_drdy;
    logic [3:0] cbe_n;
    logic [7:0] ad;
    logic       acc_cfg, cfg_sent, cfg_xfer, cfg_wr;
    logic [5:0] cfg_addr;
    logic [3:0] cfg_be;
    logic       devsel_n, trdy_n, stop_n, tgt_oe, ad_oe;
    logic [18:0] dut_vec;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a claimed access and the phases it has reached.
    bit         m_active, m_in_data, m_stop, m_turn, m_xfered, m_seen, m_prev_frame, m_wr;
    int         m_since;
    logic [5:0] m_addr;
    logic [3:0] m_be;

    pci_cfg_target #(.LAT_MAX(LAT_MAX)) dut (
        .clk(clk), .rst(rst), .frame_n(frame_n), .irdy_n(irdy_n), .idsel(idsel),
        .cbe_n(cbe_n), .ad(ad), .cfg_drdy(cfg_drdy), .acc_cfg(acc_cfg),
        .cfg_sent(cfg_sent), .cfg_xfer(cfg_xfer), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr),
        .cfg_be(cfg_be), .devsel_n(devsel_n), .trdy_n(trdy_n), .stop_n(stop_n),
        .tgt_oe(tgt_oe), .ad_oe(ad_oe)
    );

    always #5 clk = ~clk;

    assign dut_vec = {acc_cfg, cfg_sent, cfg_xfer, cfg_wr, cfg_addr, cfg_be,
                      devsel_n, trdy_n, stop_n, tgt_oe, ad_oe};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0; m_in_data = 1'b0; m_stop = 1'b0; m_turn = 1'b0;
        m_xfered = 1'b0; m_seen = 1'b0; m_prev_frame = 1'b0; m_wr = 1'b0;
        m_since = 0; m_addr = 6'd0; m_be = 4'd0;
    endtask

    // Advance the model by one rising edge using the inputs the DUT just sampled.
    task automatic model_step();
        bit ap;
        if (!rst) begin
            model_reset();
            return;
        end
        ap = !frame_n && m_prev_frame;
        if (m_turn) begin
            m_turn = 1'b0; m_active = 1'b0;
        end else if (!m_active) begin
            if (ap && idsel && cbe_n[3:1] == 3'b101 && ad[1:0] == 2'b00) begin
                m_active = 1'b1; m_since = 1; m_addr = ad[7:2]; m_wr = cbe_n[0];
                m_xfered = 1'b0; m_seen = 1'b0;
            end
        end else if (m_in_data) begin
            if (!irdy_n) begin
                m_xfered = 1'b1; m_be = ~cbe_n; m_in_data = 1'b0;
                if (frame_n) m_turn = 1'b1;
                else         m_stop = 1'b1;
            end
        end else if (m_stop) begin
            if (frame_n && m_seen) begin
                m_stop = 1'b0; m_turn = 1'b1;
            end
            if (cfg_drdy) m_seen = 1'b1;
        end else if (m_since == 1) begin
            m_since = 2;
            if (cfg_drdy) m_seen = 1'b1;
        end else begin
            if (cfg_drdy) begin
                m_seen = 1'b1; m_in_data = 1'b1;
            end else if (m_since == LAT_MAX) begin
                m_stop = 1'b1;
            end else begin
                m_since++;
            end
        end
        m_prev_frame = frame_n;
    endtask

    function automatic logic [18:0] expv();
        logic acc, dv, tr, st, xf;
        acc = m_active && !m_turn && !m_in_data && !m_stop && (m_since == 1);
        dv  = !(m_active && !m_turn);
        tr  = !m_in_data;
        st  = !(m_stop || (m_in_data && !m_prev_frame));
        xf  = m_turn && m_xfered;
        return {acc, m_turn, xf, m_wr, m_addr, m_be, dv, tr, st, m_active, m_in_data && !m_wr};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("cycle", dut_vec, expv());
    endtask

    task automatic idle_cycle();
        frame_n = 1'b1; irdy_n = 1'b1; idsel = 1'b0; cfg_drdy = 1'b0;
        cbe_n = 4'hF; ad = 8'h00;
        tick();
    endtask

    task automatic directed_read(input bit stop_at_data);
        idle_cycle();
        frame_n = 1'b0; idsel = 1'b1; cbe_n = 4'b1010; ad = 8'h10;
        tick();
        chk("rd_acc", acc_cfg, 1); chk("rd_devsel", devsel_n, 0);
        chk("rd_addr", cfg_addr, 4); chk("rd_wr", cfg_wr, 0);
        frame_n = 1'b1; idsel = 1'b0; ad = 8'h00; cbe_n = 4'b0000; irdy_n = 1'b0;
        repeat (3) tick();
        chk("rd_wait_trdy", trdy_n, 1);
        cfg_drdy = 1'b1;
        tick();
        chk("rd_trdy", trdy_n, 0); chk("rd_adoe", ad_oe, 1); chk("rd_stop", stop_n, 1);
        if (stop_at_data) return;
        tick();
        chk("rd_sent", cfg_sent, 1); chk("rd_xfer", cfg_xfer, 1); chk("rd_be", cfg_be, 4'hF);
        cfg_drdy = 1'b0;
        tick();
        chk("rd_sent_once", cfg_sent, 0); chk("rd_tgt_off", tgt_oe, 0);
    endtask

    task automatic rand_txn();
        bit good, burst, intrude;
        int drdy_dly, irdy_dly, hold, cyc, held;
        logic [7:0] a;
        logic [3:0] c;
        logic       sel;
        good     = ($urandom_range(0, 3) != 0);
        burst    = 1'($urandom_range(0, 1));
        drdy_dly = $urandom_range(0, LAT_MAX + 6);
        irdy_dly = $urandom_range(0, 5);
        hold     = $urandom_range(0, 3);
        intrude  = !burst && drdy_dly >= 4 && ($urandom_range(0, 2) == 0);
        a = 8'($urandom); a[1:0] = 2'b00;
        c = {3'b101, 1'($urandom)};
        sel = 1'b1;
        if (!good) begin
            case ($urandom_range(0, 2))
                0:       sel = 1'b0;
                1:       c = 4'b0110;
                default: a[1:0] = 2'($urandom_range(1, 3));
            endcase
        end
        idle_cycle();
        frame_n = 1'b0; idsel = sel; cbe_n = c; ad = a;
        tick();
        idsel = 1'b0; ad = 8'($urandom); cbe_n = 4'($urandom); frame_n = !burst;
        if (!good) begin
            cfg_drdy = 1'($urandom);
            repeat (3) tick();
            chk("bad_no_claim", {acc_cfg, devsel_n, tgt_oe}, 3'b010);
            return;
        end
        cyc = 0; held = 0;
        while (m_active && cyc < 200) begin
            cfg_drdy = (cyc >= drdy_dly);
            irdy_n   = !(cyc >= irdy_dly);
            if (intrude) frame_n = !(cyc == 1);
            if (burst && m_stop) begin
                if (held >= hold) frame_n = 1'b1;
                held++;
            end
            tick();
            cyc++;
        end
        chk("txn_bound", {31'd0, m_active}, 32'd0);
        chk("txn_idle", tgt_oe, 0);
    endtask

    initial begin
        rst = 1'b0;
        frame_n = 1'b1; irdy_n = 1'b1; idsel = 1'b0; cfg_drdy = 1'b0;
        cbe_n = 4'hF; ad = 8'h00;
        model_reset();
        repeat (2) tick();
        chk("reset_vec", dut_vec, 19'h0001C);
        rst = 1'b1;

        directed_read(1'b0);

        // Write with delayed IRDY#
        idle_cycle();
        frame_n = 1'b0; idsel = 1'b1; cbe_n = 4'b1011; ad = 8'h24;
        tick();
        frame_n = 1'b1; idsel = 1'b0; cbe_n = 4'b0011; cfg_drdy = 1'b1;
        repeat (2) tick();
        chk("wr_trdy", trdy_n, 0); chk("wr_adoe", ad_oe, 0);
        chk("wr_wr", cfg_wr, 1); chk("wr_addr", cfg_addr, 9);
        repeat (2) tick();
        chk("wr_trdy_hold", trdy_n, 0);
        irdy_n = 1'b0;
        tick();
        chk("wr_be", cfg_be, 4'b1100); chk("wr_xfer", {cfg_sent, cfg_xfer}, 2'b11);

        // Addresses that must not be claimed
        for (int k = 0; k < 3; k++) begin
            idle_cycle();
            frame_n = 1'b0; idsel = (k != 0); cbe_n = (k == 1) ? 4'b0110 : 4'b1010;
            ad = (k == 2) ? 8'h21 : 8'h20;
            tick();
            chk("nc_acc", acc_cfg, 0); chk("nc_devsel", devsel_n, 1); chk("nc_oe", tgt_oe, 0);
            frame_n = 1'b1;
            tick();
        end

        // Retry after LAT_MAX clocks, then late data ready
        idle_cycle();
        frame_n = 1'b0; idsel = 1'b1; cbe_n = 4'b1010; ad = 8'h3C;
        tick();
        frame_n = 1'b1; idsel = 1'b0; irdy_n = 1'b0;
        repeat (LAT_MAX - 1) tick();
        chk("to_stop_early", stop_n, 1);
        tick();
        chk("to_stop", stop_n, 0); chk("to_trdy", trdy_n, 1);
        repeat (20 - LAT_MAX) tick();
        cfg_drdy = 1'b1;
        repeat (2) tick();
        chk("to_sent", {cfg_sent, cfg_xfer}, 2'b10);
        tick();
        chk("to_sent_once", cfg_sent, 0);

        // Burst: FRAME# still low at the transfer
        idle_cycle();
        frame_n = 1'b0; idsel = 1'b1; cbe_n = 4'b1010; ad = 8'h08;
        tick();
        idsel = 1'b0; cbe_n = 4'b0101; cfg_drdy = 1'b1; irdy_n = 1'b0;
        repeat (2) tick();
        chk("bu_disc", {trdy_n, stop_n}, 2'b00);
        repeat (3) tick();
        chk("bu_stopw", {trdy_n, stop_n, devsel_n}, 3'b100);
        frame_n = 1'b1;
        tick();
        chk("bu_sent", {cfg_sent, cfg_xfer}, 2'b11); chk("bu_be", cfg_be, 4'b1010);

        // Asynchronous reset in the data phase
        directed_read(1'b1);
        #2 rst = 1'b0;
        #1 model_reset();
        chk("arst_vec", dut_vec, 19'h0001C);
        frame_n = 1'b0; idsel = 1'b1; cbe_n = 4'b1010; ad = 8'h08; cfg_drdy = 1'b0;
        tick();
        rst = 1'b1;
        repeat (2) tick();
        chk("arst_no_claim", acc_cfg, 0);
        directed_read(1'b0);

        for (int t = 0; t < 40; t++) rand_txn();
        idle_cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
